// File: rtl/xor_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared XOR datapath.
// Each transaction runs LOAD -> EVAL -> DONE on operands captured into internal registers.

module xorCell (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] supply,
    output logic       y
);
    // The rails only matter for physical hookup; the behavioural cell does not use them.
    logic unusedSupply;
    assign unusedSupply = ^supply;
    assign y = a ^ b;
endmodule

module xor_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic [1:0]               DigitSupply,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] OpA,
    input  logic [NUM_REQ*WIDTH-1:0] OpB,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Done,
    output logic [WIDTH-1:0]         Result,
    output logic                     Busy
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StLoad, StEval, StDone} arbState;

    arbState         stateQ, stateD;
    logic [IdxW-1:0] winnerQ, winnerD;
    logic [IdxW-1:0] pointerQ, pointerD;
    logic [IdxW-1:0] pick, cand;
    logic            found;
    logic [WIDTH-1:0] opAQ, opAD, opBQ, opBD;
    logic [WIDTH-1:0] resultQ, resultD;
    logic [WIDTH-1:0] xorOut;

    for (genvar i = 0; i < WIDTH; i++) begin : gXor
        xorCell uXor (
            .a      (opAQ[i]),
            .b      (opBQ[i]),
            .supply (DigitSupply),
            .y      (xorOut[i])
        );
    end

    // Search upward from the slot after the last-served requester, wrapping at NUM_REQ.
    always_comb begin
        pick  = pointerQ;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(pointerQ) + k) % NUM_REQ);
            if (!found && Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        stateD   = stateQ;
        winnerD  = winnerQ;
        pointerD = pointerQ;
        opAD     = opAQ;
        opBD     = opBQ;
        resultD  = resultQ;
        unique case (stateQ)
            StIdle: begin
                if (|Req) begin
                    winnerD = pick;
                    stateD  = StLoad;
                end
            end
            StLoad: begin
                if (Req[winnerQ]) begin
                    opAD   = OpA[32'(winnerQ) * WIDTH +: WIDTH];
                    opBD   = OpB[32'(winnerQ) * WIDTH +: WIDTH];
                    stateD = StEval;
                end else begin
                    stateD = StIdle;
                end
            end
            StEval: begin
                resultD = xorOut;
                stateD  = StDone;
            end
            StDone: begin
                pointerD = winnerQ;
                stateD   = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        Grant = '0;
        Done  = '0;
        if (stateQ != StIdle) begin
            Grant[winnerQ] = 1'b1;
        end
        if (stateQ == StDone) begin
            Done[winnerQ] = 1'b1;
        end
    end

    assign Busy   = (stateQ != StIdle);
    assign Result = resultQ;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            stateQ   <= StIdle;
            winnerQ  <= '0;
            pointerQ <= IdxW'(NUM_REQ - 1);
            opAQ     <= '0;
            opBQ     <= '0;
            resultQ  <= '0;
        end else begin
            stateQ   <= stateD;
            winnerQ  <= winnerD;
            pointerQ <= pointerD;
            opAQ     <= opAD;
            opBQ     <= opBD;
            resultQ  <= resultD;
        end
    end
endmodule

// File: tb/tb_xor_arbiter.sv
// Self-checking bench for xor_arbiter: expected completions are queued when stimulus is
// driven and popped whenever the DUT pulses Done.

module tb_xor_arbiter;
    localparam int NR = 4;
    localparam int W  = 8;

    typedef struct {
        int         idx;
        logic [7:0] res;
    } sbEntry;

    logic            clock = 1'b0;
    logic            nReset;
    logic [1:0]      digitSupply;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] opA;
    logic [NR*W-1:0] opB;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic [W-1:0]    result;
    logic            busy;

    int         nChecks;
    int         nPass;
    int         cycle;
    sbEntry     sbq[$];
    int         doneCycles[$];
    logic [7:0] aVal[NR];
    logic [7:0] bVal[NR];

    xor_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W)
    ) dut (
        .Clock       (clock),
        .nReset      (nReset),
        .DigitSupply (digitSupply),
        .Req         (req),
        .OpA         (opA),
        .OpB         (opB),
        .Grant       (grant),
        .Done        (done),
        .Result      (result),
        .Busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic expectDone(input int idx, input logic [7:0] res);
        sbEntry e;
        e.idx = idx;
        e.res = res;
        sbq.push_back(e);
    endtask

    task automatic setOps(input int i, input logic [7:0] a, input logic [7:0] b);
        opA[i*W +: W] = a;
        opB[i*W +: W] = b;
    endtask

    // Advance one cycle, sample just after the edge, and retire any completion.
    task automatic tick();
        sbEntry e;
        @(posedge clock);
        #1;
        cycle++;
        checkEq("grantOneHot0", 32'($onehot0(grant)), 32'd1);
        if (done != '0) begin
            doneCycles.push_back(cycle);
            if (sbq.size() == 0) begin
                checkEq("unexpectedDone", 32'(done), 32'd0);
            end else begin
                e = sbq.pop_front();
                checkEq("doneReq", 32'(done), 32'(1 << e.idx));
                checkEq("doneResult", 32'(result), 32'(e.res));
            end
        end
    endtask

    initial begin
        nChecks     = 0;
        nPass       = 0;
        cycle       = 0;
        digitSupply = 2'b10;
        nReset      = 1'b0;
        req         = 4'b1111;
        opA         = '0;
        opB         = '0;

        // Reset held with all requests asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            checkEq("rstGrant", 32'(grant), 32'd0);
            checkEq("rstDone", 32'(done), 32'd0);
            checkEq("rstResult", 32'(result), 32'd0);
            checkEq("rstBusy", 32'(busy), 32'd0);
        end
        nReset = 1'b1;
        req    = '0;
        tick();

        // Single transaction, latency and result.
        setOps(0, 8'hA5, 8'h0F);
        req = 4'b0001;
        expectDone(0, 8'hAA);
        tick();
        checkEq("singleGrant1", 32'(grant), 32'b0001);
        checkEq("singleBusy1", 32'(busy), 32'd1);
        tick();
        checkEq("singleGrant2", 32'(grant), 32'b0001);
        checkEq("singleNoEarlyDone", 32'(done), 32'd0);
        req = '0;
        tick();
        checkEq("singleGrant3", 32'(grant), 32'b0001);
        checkEq("singleDone", 32'(done), 32'b0001);
        tick();
        checkEq("singleIdleGrant", 32'(grant), 32'd0);
        checkEq("singleIdleBusy", 32'(busy), 32'd0);
        checkEq("singleHoldResult", 32'(result), 32'hAA);

        // Round-robin with all requests held, starting from reset priority.
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            aVal[i] = 8'(17 * (i + 1));
            bVal[i] = 8'(240 >> i);
            setOps(i, aVal[i], bVal[i]);
        end
        doneCycles.delete();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expectDone(k % NR, aVal[k % NR] ^ bVal[k % NR]);
            tick();
            checkEq("rrGrant", 32'(grant), 32'(1 << (k % NR)));
            tick();
            tick();
            checkEq("rrDoneGrant", 32'(grant), 32'(1 << (k % NR)));
            if (k == 4) req = '0;
            tick();
            checkEq("rrIdleBusy", 32'(busy), 32'd0);
        end
        checkEq("rrDoneCount", 32'(doneCycles.size()), 32'd5);
        for (int k = 1; k < doneCycles.size(); k++) begin
            checkEq("rrSpacing", 32'(doneCycles[k] - doneCycles[k-1]), 32'd4);
        end

        // Abort in LOAD leaves pointer and Result alone.
        req = 4'b0100;
        tick();
        checkEq("abortGrant", 32'(grant), 32'b0100);
        req = '0;
        tick();
        checkEq("abortBusy", 32'(busy), 32'd0);
        checkEq("abortGrantIdle", 32'(grant), 32'd0);
        checkEq("abortResult", 32'(result), 32'(aVal[0] ^ bVal[0]));
        tick();
        checkEq("abortStayIdle", 32'(busy), 32'd0);
        req = 4'b1100;
        expectDone(2, aVal[2] ^ bVal[2]);
        tick();
        checkEq("afterAbortGrant", 32'(grant), 32'b0100);
        tick();
        tick();
        req = '0;
        tick();

        // Operand change during EVAL must not leak into the result.
        setOps(1, 8'h3C, 8'hC3);
        req = 4'b0010;
        expectDone(1, 8'hFF);
        tick();
        checkEq("captureGrant", 32'(grant), 32'b0010);
        tick();
        setOps(1, 8'hFF, 8'hC3);
        req = '0;
        tick();
        tick();
        checkEq("captureHold", 32'(result), 32'hFF);

        // Reset during EVAL kills the transaction.
        setOps(1, 8'h5A, 8'hFF);
        req = 4'b0010;
        tick();
        tick();
        nReset = 1'b0;
        req    = '0;
        tick();
        checkEq("midRstGrant", 32'(grant), 32'd0);
        checkEq("midRstDone", 32'(done), 32'd0);
        checkEq("midRstResult", 32'(result), 32'd0);
        checkEq("midRstBusy", 32'(busy), 32'd0);
        nReset = 1'b1;
        tick();
        tick();
        req = 4'b0010;
        expectDone(1, 8'hA5);
        tick();
        checkEq("postRstGrant", 32'(grant), 32'b0010);
        tick();
        req = '0;
        tick();
        tick();

        checkEq("scoreboardEmpty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
